// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared types and helpers for the line buffer sequencer
package line_buf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME0 = 2'd1,
      PRIME1 = 2'd2,
      RUN    = 2'd3
   } lbc_state_t;

   localparam int NUM_ROWS = 3;

   // Next BRAM in the write rotation, wrapping after the last row buffer
   function automatic logic [1:0] sel_next(input logic [1:0] s);
      return (s == 2'(NUM_ROWS - 1)) ? 2'd0 : s + 2'd1;
   endfunction

endpackage

// File: rtl/vid_delay_pipe.sv
// rtl/vid_delay_pipe.sv - fixed-depth register pipe aligning stream side-band with BRAM reads
module vid_delay_pipe #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - row-buffer write rotation and window sequencing for the 3x3 kernel
// Define LBC_BORDER_FLAGS_EN to export o_win_first_col / o_win_last_col edge flags.
module line_buf_ctrl
   import line_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int H_ACTIVE   = 1920,
   parameter int ADDR_W     = 11,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_vid_data,
   input  logic                  i_vid_hsync,
   input  logic                  i_vid_vsync,
   input  logic                  i_vid_VDE,
   input  logic                  i_en,
   output logic [2:0]            o_bram_we,
   output logic [ADDR_W-1:0]     o_bram_addr,
   output logic [1:0]            o_top_sel,
   output logic [1:0]            o_mid_sel,
   output logic [DATA_WIDTH-1:0] o_cur_data,
   output logic                  o_win_valid,
`ifdef LBC_BORDER_FLAGS_EN
   output logic                  o_win_first_col,
   output logic                  o_win_last_col,
`endif
   output logic                  o_vid_hsync,
   output logic                  o_vid_vsync,
   output logic                  o_vid_VDE,
   output logic [1:0]            o_state,
   output logic                  o_line_err
);

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_ACTIVE - 1);
`ifdef LBC_BORDER_FLAGS_EN
   localparam int PIPE_W = DATA_WIDTH + 6;
`else
   localparam int PIPE_W = DATA_WIDTH + 4;
`endif

   lbc_state_t        state;
   logic [ADDR_W-1:0] col;
   logic [1:0]        wr_sel;
   logic              vsync_q;
   logic              vde_q;
   logic              line_done;
   logic              vs_rise;
   logic              run_ok;
   logic              pix;
   logic              line_end;
   logic              win;
   logic [PIPE_W-1:0] pipe_in;
   logic [PIPE_W-1:0] pipe_out;

   assign vs_rise = i_vid_vsync & ~vsync_q;
   assign run_ok  = i_en & ~vs_rise & (state != IDLE);
   assign pix     = run_ok & i_vid_VDE & ~line_done;
   // A falling VDE only closes a line that actually wrote pixels and has not already wrapped
   assign line_end = (pix & (col == COL_LAST))
                   | (run_ok & vde_q & ~i_vid_VDE & ~line_done & (col != '0));
   assign win     = i_en & ~vs_rise & i_vid_VDE & (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         col         <= '0;
         wr_sel      <= '0;
         o_top_sel   <= '0;
         o_mid_sel   <= '0;
         o_bram_we   <= '0;
         o_bram_addr <= '0;
         o_line_err  <= 1'b0;
         vsync_q     <= 1'b0;
         vde_q       <= 1'b0;
         line_done   <= 1'b0;
      end else begin
         vsync_q   <= i_vid_vsync;
         vde_q     <= i_vid_VDE;
         o_bram_we <= pix ? (3'b001 << wr_sel) : 3'b000;
         if (pix) o_bram_addr <= col;

         if (!i_en) begin
            state     <= IDLE;
            col       <= '0;
            wr_sel    <= '0;
            line_done <= 1'b0;
         end else if (vs_rise) begin
            state      <= PRIME0;
            col        <= '0;
            wr_sel     <= '0;
            line_done  <= 1'b0;
            o_line_err <= 1'b0;
         end else if (state != IDLE) begin
            if (line_end) begin
               col       <= '0;
               wr_sel    <= sel_next(wr_sel);
               o_mid_sel <= wr_sel;
               o_top_sel <= o_mid_sel;
               state     <= (state == PRIME0) ? PRIME1 : RUN;
            end else if (pix) begin
               col <= col + ADDR_W'(1);
            end

            // Once a full line has wrapped, further VDE pixels are overrun until VDE drops
            if (pix && (col == COL_LAST)) line_done <= 1'b1;
            else if (!i_vid_VDE)          line_done <= 1'b0;

            if ((i_vid_VDE & line_done) | (line_end & ~i_vid_VDE)) o_line_err <= 1'b1;
         end
      end
   end

   assign o_state = state;

`ifdef LBC_BORDER_FLAGS_EN
   assign pipe_in = {pix & (col == '0), pix & (col == COL_LAST), win,
                     i_vid_VDE, i_vid_vsync, i_vid_hsync, i_vid_data};
   assign {o_win_first_col, o_win_last_col, o_win_valid,
           o_vid_VDE, o_vid_vsync, o_vid_hsync, o_cur_data} = pipe_out;
`else
   assign pipe_in = {win, i_vid_VDE, i_vid_vsync, i_vid_hsync, i_vid_data};
   assign {o_win_valid, o_vid_VDE, o_vid_vsync, o_vid_hsync, o_cur_data} = pipe_out;
`endif

   vid_delay_pipe #(
      .WIDTH (PIPE_W),
      .DEPTH (1 + RD_LAT)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (pipe_in),
      .dout (pipe_out)
   );

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - randomized and directed check of line_buf_ctrl against a row-level model
module tb_line_buf_ctrl;

   localparam int DW = 24;
   localparam int HA = 8;
   localparam int AW = 3;
   localparam int RL = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] vid_data = '0;
   logic          hs = 1'b0, vs = 1'b0, vde = 1'b0, en = 1'b0;
   logic [2:0]    bram_we;
   logic [AW-1:0] bram_addr;
   logic [1:0]    top_sel, mid_sel, state;
   logic [DW-1:0] cur_data;
   logic          win_valid, o_hs, o_vs, o_vde, line_err;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   line_buf_ctrl #(.DATA_WIDTH(DW), .H_ACTIVE(HA), .ADDR_W(AW), .RD_LAT(RL)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_vid_data  (vid_data),
      .i_vid_hsync (hs),
      .i_vid_vsync (vs),
      .i_vid_VDE   (vde),
      .i_en        (en),
      .o_bram_we   (bram_we),
      .o_bram_addr (bram_addr),
      .o_top_sel   (top_sel),
      .o_mid_sel   (mid_sel),
      .o_cur_data  (cur_data),
      .o_win_valid (win_valid),
      .o_vid_hsync (o_hs),
      .o_vid_vsync (o_vs),
      .o_vid_VDE   (o_vde),
      .o_state     (state),
      .o_line_err  (line_err)
   );

   // Row-level model: lines completed this frame, pixels in current line, history of written rows
   typedef struct packed {
      logic [DW-1:0] d;
      logic h, v, e, w;
   } dly_t;

   dly_t          m_pipe [0:RL];
   bit            m_idle = 1'b1, m_over = 1'b0, m_err = 1'b0, m_pvs = 1'b0, m_pvde = 1'b0;
   int            m_rows = 0, m_pix = 0;
   logic [2:0]    m_we = '0;
   logic [AW-1:0] m_addr = '0;
   int            m_hist[$];

   task automatic end_line();
      m_hist.push_back(m_rows % 3);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      m_rows++;
      m_pix = 0;
   endtask

   task automatic model_step();
      bit rise, fall, win;
      rise = vs && !m_pvs;
      fall = m_pvde && !vde;
      win  = en && !rise && vde && !m_idle && (m_rows >= 2);
      m_we = 3'b000;
      if (!en) begin
         m_idle = 1'b1; m_rows = 0; m_pix = 0; m_over = 1'b0;
      end else if (rise) begin
         m_idle = 1'b0; m_rows = 0; m_pix = 0; m_over = 1'b0; m_err = 1'b0;
      end else if (!m_idle) begin
         if (vde) begin
            if (m_over) m_err = 1'b1;
            else begin
               m_we   = 3'b001 << (m_rows % 3);
               m_addr = AW'(m_pix);
               m_pix++;
               if (m_pix == HA) begin
                  end_line();
                  m_over = 1'b1;
               end
            end
         end else if (fall) begin
            if (m_over) m_over = 1'b0;
            else if (m_pix != 0) begin
               end_line();
               m_err = 1'b1;
            end
         end
      end
      m_pvs  = vs;
      m_pvde = vde;
      for (int i = RL; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = '{d: vid_data, h: hs, v: vs, e: vde, w: win};
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle = 1'b1; m_over = 1'b0; m_err = 1'b0; m_pvs = 1'b0; m_pvde = 1'b0;
         m_rows = 0; m_pix = 0; m_we = '0; m_addr = '0;
         m_hist = '{0, 0};
         for (int i = 0; i <= RL; i++) m_pipe[i] = '0;
      end else begin
         model_step();
      end
   end

   function automatic int exp_state();
      if (m_idle) return 0;
      if (m_rows == 0) return 1;
      if (m_rows == 1) return 2;
      return 3;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("we",       32'(bram_we),   32'(m_we));
         cmp("addr",     32'(bram_addr), 32'(m_addr));
         cmp("top_sel",  32'(top_sel),   32'(m_hist[0]));
         cmp("mid_sel",  32'(mid_sel),   32'(m_hist[1]));
         cmp("state",    32'(state),     32'(exp_state()));
         cmp("line_err", 32'(line_err),  32'(m_err));
         cmp("cur_data", 32'(cur_data),  32'(m_pipe[RL].d));
         cmp("win",      32'(win_valid), 32'(m_pipe[RL].w));
         cmp("hsync",    32'(o_hs),      32'(m_pipe[RL].h));
         cmp("vsync",    32'(o_vs),      32'(m_pipe[RL].v));
         cmp("vde",      32'(o_vde),     32'(m_pipe[RL].e));
      end
   end

   logic [2:0]    l_first_we, l_last_we;
   logic [AW-1:0] l_first_addr;
   logic [1:0]    l_state, l_top, l_mid;
   int            l_win, l_win_first;

   task automatic cyc(input bit e, input bit h, input bit v);
      vde = e; hs = h; vs = v;
      vid_data = e ? DW'($urandom) : '0;
      @(negedge clk);
   endtask

   task automatic line(input int n, input int gap);
      l_win = 0;
      l_win_first = -1;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         if (i == 0) begin
            l_first_we = bram_we; l_first_addr = bram_addr; l_state = state;
            l_top = top_sel; l_mid = mid_sel;
         end
         l_last_we = bram_we;
         if (win_valid) begin l_win++; if (l_win_first < 0) l_win_first = i; end
      end
      for (int i = 0; i < gap; i++) begin
         cyc(1'b0, i == 0, 1'b0);
         if (win_valid) begin l_win++; if (l_win_first < 0) l_win_first = n + i; end
      end
   endtask

   task automatic vsync_pulse();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int r, n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      cmp("lit_rst_state", 32'(state), 0);
      cmp("lit_rst_we",    32'(bram_we), 0);
      cmp("lit_rst_err",   32'(line_err), 0);
      cmp("lit_rst_win",   32'(win_valid), 0);

      en = 1'b1;
      vsync_pulse();
      line(8, 3);
      cmp("lit_l1_we", 32'(l_first_we), 32'h1);
      cmp("lit_l1_state", 32'(l_state), 1);
      cmp("lit_l1_addr", 32'(l_first_addr), 0);
      line(8, 3);
      cmp("lit_l2_we", 32'(l_first_we), 32'h2);
      cmp("lit_l2_state", 32'(l_state), 2);
      line(8, 3);
      cmp("lit_l3_we", 32'(l_first_we), 32'h4);
      cmp("lit_l3_state", 32'(l_state), 3);
      line(8, 3);
      cmp("lit_l4_we", 32'(l_first_we), 32'h1);
      cmp("lit_l4_top", 32'(l_top), 1);
      cmp("lit_l4_mid", 32'(l_mid), 2);
      cmp("lit_l4_win_cnt", 32'(l_win), 8);
      cmp("lit_l4_win_first", 32'(l_win_first), 1);

      line(6, 3);
      cmp("lit_short_err", 32'(line_err), 1);
      line(8, 3);
      cmp("lit_after_short_we", 32'(l_first_we), 32'h4);
      cmp("lit_after_short_addr", 32'(l_first_addr), 0);
      vsync_pulse();
      cmp("lit_vsync_clr_err", 32'(line_err), 0);

      line(8, 3);
      line(10, 3);
      cmp("lit_long_we", 32'(l_first_we), 32'h2);
      cmp("lit_long_extra_we", 32'(l_last_we), 0);
      cmp("lit_long_err", 32'(line_err), 1);
      line(8, 3);
      cmp("lit_after_long_we", 32'(l_first_we), 32'h4);

      cyc(1'b1, 1'b0, 1'b1);
      cmp("lit_vs_vde_we", 32'(bram_we), 0);
      cmp("lit_vs_vde_state", 32'(state), 1);
      cyc(1'b0, 1'b0, 1'b1);
      cmp("lit_vs_vde_win", 32'(win_valid), 0);
      cyc(1'b0, 1'b0, 1'b0);
      line(8, 3);
      cmp("lit_vs_vde_next_we", 32'(l_first_we), 32'h1);
      cmp("lit_vs_vde_next_win", 32'(l_win), 0);

      line(8, 3);
      line(8, 3);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      cmp("lit_midrst_we", 32'(bram_we), 0);
      cmp("lit_midrst_state", 32'(state), 0);
      cmp("lit_midrst_addr", 32'(bram_addr), 0);
      cmp("lit_midrst_data", 32'(cur_data), 0);
      cmp("lit_midrst_mid", 32'(mid_sel), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         cmp("lit_postrst_we", 32'(bram_we), 0);
         cmp("lit_postrst_state", 32'(state), 0);
      end
      cyc(1'b0, 1'b0, 1'b0);

      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
         end else if (r < 10) begin
            vsync_pulse();
         end else if (r < 14) begin
            en = 1'b0;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            en = 1'b1;
         end else begin
            n = ($urandom_range(0, 1) == 1) ? HA : $urandom_range(1, 12);
            line(n, $urandom_range(1, 4));
         end
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b0);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
